// File: rtl/lsu_gled_arbiter.sv
// Two-requester arbiter for the byte-wide LED/IO buffer: splits byte/half/word
// requests into single-byte beats and returns sign/zero-extended load data.
module lsu_gled_arbiter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              r0_valid_i,
    output logic              r0_ready_o,
    input  logic              r0_we_i,
    input  logic [2:0]        r0_mode_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [31:0]       r0_wdata_i,
    output logic              r0_rvalid_o,
    output logic [31:0]       r0_rdata_o,
    input  logic              r1_valid_i,
    output logic              r1_ready_o,
    input  logic              r1_we_i,
    input  logic [2:0]        r1_mode_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [31:0]       r1_wdata_i,
    output logic              r1_rvalid_o,
    output logic [31:0]       r1_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [1:0]        k_q, k_d;
    logic              we_q, we_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       res_q, res_d;

    logic idle, beat, resp, gnt0, gnt1, accept, sel1;
    logic [31:0] rdata_ext;

    // Index of the final beat: 0 for byte, 1 for half, 3 for word (incl. modes 3/6/7).
    function automatic logic [1:0] last_beat(input logic [2:0] mode);
        case (mode[1:0])
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [31:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        case (mode)
            3'd0:    return 32'(b);
            3'd1:    return 32'(h);
            3'd4:    return {24'd0, raw[7:0]};
            3'd5:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign idle = (state_q == S_IDLE);
    assign beat = (state_q == S_BEAT);
    assign resp = (state_q == S_RESP);

    // last_q == 1 means r1 was served last, so r0 wins a tie.
    assign gnt0 = r0_valid_i && (!r1_valid_i || last_q);
    assign gnt1 = r1_valid_i && (!r0_valid_i || !last_q);

    assign r0_ready_o = rst_ni && idle && gnt0;
    assign r1_ready_o = rst_ni && idle && gnt1;
    assign accept     = r0_ready_o || r1_ready_o;
    assign sel1       = r1_ready_o;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        k_d     = k_q;
        we_d    = we_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_BEAT;
                    owner_d = sel1;
                    last_d  = sel1;
                    k_d     = 2'd0;
                    we_d    = sel1 ? r1_we_i    : r0_we_i;
                    mode_d  = sel1 ? r1_mode_i  : r0_mode_i;
                    addr_d  = sel1 ? r1_addr_i  : r0_addr_i;
                    wdata_d = sel1 ? r1_wdata_i : r0_wdata_i;
                    res_d   = 32'd0;
                end
            end
            S_BEAT: begin
                if (!we_q) begin
                    res_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
                end
                k_d = k_q + 2'd1;
                if (k_q == last_beat(mode_q)) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            k_q     <= k_d;
        end
    end

    // Request payload and load assembly; only observed while BEAT/RESP are active.
    always_ff @(posedge clk_i) begin
        we_q    <= we_d;
        mode_q  <= mode_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        res_q   <= res_d;
    end

    assign busy_o      = !idle;
    assign mem_we_o    = beat && we_q;
    assign mem_addr_o  = beat ? (addr_q + ADDR_W'(k_q)) : '0;
    assign mem_wdata_o = (beat && we_q) ? wdata_q[{k_q, 3'b000} +: 8] : 8'd0;

    assign rdata_ext   = we_q ? 32'd0 : load_extend(mode_q, res_q);
    assign r0_rvalid_o = resp && !owner_q;
    assign r1_rvalid_o = resp && owner_q;
    assign r0_rdata_o  = r0_rvalid_o ? rdata_ext : 32'd0;
    assign r1_rdata_o  = r1_rvalid_o ? rdata_ext : 32'd0;

endmodule

// File: tb/tb_lsu_gled_arbiter.sv
// Bench for lsu_gled_arbiter: directed vector table, randomized requests checked
// against a byte-array model, plus reset-abort and round-robin sequences.
module tb_lsu_gled_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  valid, we;
    logic [2:0]  mode [2];
    logic [3:0]  addr [2];
    logic [31:0] wdata [2];
    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_we, busy;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [16] = '{default: 8'h00};
    logic [7:0]  ref_mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_gled_arbiter #(.ADDR_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_valid_i(valid[0]), .r0_ready_o(r0_ready), .r0_we_i(we[0]), .r0_mode_i(mode[0]),
        .r0_addr_i(addr[0]), .r0_wdata_i(wdata[0]), .r0_rvalid_o(r0_rvalid), .r0_rdata_o(r0_rdata),
        .r1_valid_i(valid[1]), .r1_ready_o(r1_ready), .r1_we_i(we[1]), .r1_mode_i(mode[1]),
        .r1_addr_i(addr[1]), .r1_wdata_i(wdata[1]), .r1_rvalid_o(r1_rvalid), .r1_rdata_o(r1_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        int        p;
        bit        st;
        bit [2:0]  md;
        bit [3:0]  ad;
        bit [31:0] wd;
        bit [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? r0_ready : r1_ready;
    endfunction
    function automatic logic rv(input int p);
        return (p == 0) ? r0_rvalid : r1_rvalid;
    endfunction
    function automatic logic [31:0] rd(input int p);
        return (p == 0) ? r0_rdata : r1_rdata;
    endfunction

    function automatic int beats(input bit [2:0] md);
        if (md == 3'd0 || md == 3'd4) return 1;
        if (md == 3'd1 || md == 3'd5) return 2;
        return 4;
    endfunction

    // Load value from the model memory: little-endian bytes, then RV extension rules.
    function automatic logic [31:0] model_load(input bit [2:0] md, input bit [3:0] ad);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < beats(md); i++)
            v = v + (32'(ref_mem[(int'(ad) + i) % 16]) << (8 * i));
        if (md == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
        if (md == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge of the RESP cycle.
    task automatic do_req(input int p, input bit st, input bit [2:0] md, input bit [3:0] ad,
                          input bit [31:0] wd, input bit [31:0] exp, input string nm);
        int  n, waitc;
        bit  got;
        logic [3:0] ea;
        n = beats(md);
        valid[p] = 1'b1; we[p] = st; mode[p] = md; addr[p] = ad; wdata[p] = wd;
        waitc = 0; got = 0;
        while (!got && waitc < 20) begin
            #1;
            if (rdy(p)) got = 1;
            else begin @(negedge clk); waitc++; end
        end
        check({nm, " accept"}, 32'(got), 32'd1);
        if (!got) begin valid[p] = 1'b0; return; end
        @(posedge clk); #1;
        valid[p] = 1'b0; we[p] = 1'($urandom); mode[p] = 3'($urandom);
        addr[p] = 4'($urandom); wdata[p] = $urandom;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ea = 4'((int'(ad) + k) % 16);
            check($sformatf("%s beat%0d addr", nm, k), 32'(mem_addr), 32'(ea));
            check($sformatf("%s beat%0d we", nm, k), 32'(mem_we), 32'(st));
            if (st) begin
                check($sformatf("%s beat%0d wdata", nm, k), 32'(mem_wdata), 32'(wd[8*k +: 8]));
                ref_mem[ea] = wd[8*k +: 8];
            end
            check($sformatf("%s beat%0d no rvalid", nm, k), 32'({r0_rvalid, r1_rvalid}), 32'd0);
        end
        @(negedge clk);
        check({nm, " rvalid"}, 32'(rv(p)), 32'd1);
        check({nm, " rdata"}, rd(p), exp);
        check({nm, " other quiet"}, {31'd0, rv(1 - p)} | rd(1 - p), 32'd0);
        check({nm, " resp mem idle"}, 32'({mem_we, mem_addr}), 32'd0);
    endtask

    initial begin
        int   p;
        bit   st;
        bit [2:0]  md;
        bit [3:0]  ad;
        bit [31:0] wd, exp;
        logic [7:0] pre10, pre11;
        bit   bad;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; valid = 2'b11; we = 2'b00;
        for (int i = 0; i < 2; i++) begin mode[i] = 0; addr[i] = 0; wdata[i] = 0; end

        tbl[0]  = '{0, 1, 3'd2, 4'd0,  32'hDEADBEEF, 32'h00000000};
        tbl[1]  = '{1, 1, 3'd1, 4'd2,  32'h00008534, 32'h00000000};
        tbl[2]  = '{1, 0, 3'd1, 4'd2,  32'h0,        32'hFFFF8534};
        tbl[3]  = '{1, 0, 3'd5, 4'd2,  32'h0,        32'h00008534};
        tbl[4]  = '{0, 0, 3'd2, 4'd0,  32'h0,        32'h8534BEEF};
        tbl[5]  = '{0, 1, 3'd2, 4'd14, 32'h11223344, 32'h00000000};
        tbl[6]  = '{0, 0, 3'd2, 4'd14, 32'h0,        32'h11223344};
        tbl[7]  = '{0, 1, 3'd0, 4'd15, 32'h123456AA, 32'h00000000};
        tbl[8]  = '{0, 0, 3'd0, 4'd15, 32'h0,        32'hFFFFFFAA};
        tbl[9]  = '{1, 0, 3'd4, 4'd15, 32'h0,        32'h000000AA};
        tbl[10] = '{0, 0, 3'd3, 4'd14, 32'h0,        32'h1122AA44};
        tbl[11] = '{1, 1, 3'd7, 4'd4,  32'hCAFEF00D, 32'h00000000};
        tbl[12] = '{1, 0, 3'd2, 4'd4,  32'h0,        32'hCAFEF00D};
        tbl[13] = '{0, 0, 3'd0, 4'd5,  32'h0,        32'hFFFFFFF0};
        tbl[14] = '{0, 0, 3'd1, 4'd6,  32'h0,        32'hFFFFCAFE};
        tbl[15] = '{0, 0, 3'd5, 4'd4,  32'h0,        32'h0000F00D};
        tbl[16] = '{1, 0, 3'd6, 4'd2,  32'h0,        32'hF00D8534};

        // Reset state, with both requesters valid
        @(negedge clk); @(negedge clk); #1;
        check("reset ready", 32'({r0_ready, r1_ready}), 32'd0);
        check("reset rvalid/busy", 32'({r0_rvalid, r1_rvalid, busy}), 32'd0);
        check("reset mem outputs", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
        check("reset rdata", r0_rdata | r1_rdata, 32'd0);
        valid = 2'b00;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++)
            do_req(tbl[i].p, tbl[i].st, tbl[i].md, tbl[i].ad, tbl[i].wd, tbl[i].exp,
                   $sformatf("vec%0d", i));
        check("sb writes only addr 15", 32'({mem[14], mem[15]}), 32'h44AA);

        for (int i = 0; i < 40; i++) begin
            p  = int'($urandom_range(0, 1));
            st = 1'($urandom);
            md = 3'($urandom);
            ad = 4'($urandom);
            wd = $urandom;
            exp = st ? 32'd0 : model_load(md, ad);
            do_req(p, st, md, ad, wd, exp, $sformatf("rnd%0d", i));
        end

        // Reset during the third beat of a word store aborts it
        pre10 = mem[10]; pre11 = mem[11];
        @(negedge clk);
        valid[0] = 1'b1; we[0] = 1'b1; mode[0] = 3'd2; addr[0] = 4'd8; wdata[0] = 32'h55667788;
        #1;
        check("abort accept", 32'(r0_ready), 32'd1);
        @(posedge clk); #1; valid[0] = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 1'b0; valid[0] = 1'b1; #1;
        check("abort outputs zero", 32'({mem_we, mem_addr, mem_wdata, busy, r0_ready, r1_ready}), 32'd0);
        @(negedge clk); @(negedge clk);
        valid[0] = 1'b0; rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (r0_rvalid || r1_rvalid || mem_we || busy) bad = 1;
        end
        check("abort no rvalid/writes after release", 32'(bad), 32'd0);
        check("abort bytes written", 32'({mem[8], mem[9], mem[10], mem[11]}),
              {16'h8877, pre10, pre11});
        ref_mem[8] = 8'h88; ref_mem[9] = 8'h77;

        // Simultaneous requests after reset: r0 first, then r1
        valid = 2'b11;
        we[0] = 1'b0; mode[0] = 3'd2; addr[0] = 4'd8;
        we[1] = 1'b0; mode[1] = 3'd4; addr[1] = 4'd9;
        exp = model_load(3'd2, 4'd8);
        #1;
        check("tie ready", 32'({r1_ready, r0_ready}), 32'b01);
        @(posedge clk); #1; valid[0] = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (r1_ready) bad = 1;
        end
        check("tie r1 held off", 32'(bad), 32'd0);
        check("tie r0 rvalid", 32'({r0_rvalid, r1_rvalid}), 32'b10);
        check("tie r0 rdata", r0_rdata, exp);
        @(negedge clk); #1;
        check("tie r1 granted next", 32'({r1_ready, r0_ready}), 32'b10);
        @(posedge clk); #1; valid[1] = 1'b0;
        @(negedge clk);
        check("tie r1 beat addr", 32'(mem_addr), 32'd9);
        @(negedge clk);
        check("tie r1 rvalid", 32'({r0_rvalid, r1_rvalid}), 32'b01);
        check("tie r1 rdata", r1_rdata, 32'h00000077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
